// File: rtl/gzip_pkg.sv
// Shared types and helpers for the LZ77 stream controller.
// Token layout, FSM states and width helpers.
package gzip_pkg;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    CLEAR
  } state_e;

  function automatic int clogb2(input int depth);
    int r;
    r = 0;
    for (int v = depth - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

  localparam int DW_DEF    = 8;
  localparam int DICT_DEF  = 16;
  localparam int LA_DEF    = 8;
  localparam int POS_W_DEF = clogb2(DICT_DEF);
  localparam int LEN_W_DEF = clogb2(LA_DEF);

  typedef struct packed {
    logic [POS_W_DEF-1:0] pos;
    logic [LEN_W_DEF-1:0] len;
    logic [DW_DEF-1:0]    sym;
    logic                 sym_vld;
    logic                 last;
  } lz77_tok_t;

endpackage

// File: rtl/lz77_tok_reg.sv
// One-deep token holding register with valid/ready.
// A load in the same cycle as a drain keeps the register full.
module lz77_tok_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] din_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q;

  assign valid_d = load_i | (valid_q & ~ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) data_q <= din_i;
    end
  end

  assign valid_o = valid_q;
  assign dout_o  = data_q;

endmodule

// File: rtl/lz77_stream_ctrl.sv
// Sequencer for the LZ77 core: feeds bytes, captures tokens,
// flushes a pending match at block end and clears the core.
module lz77_stream_ctrl
  import gzip_pkg::*;
#(
  parameter int DATA_WIDTH            = 8,
  parameter int DICTIONARY_DEPTH      = 16,
  parameter int LOOK_AHEAD_BUFF_DEPTH = 8,
  parameter int STAT_W                = 16,
  localparam int POS_W = clogb2(DICTIONARY_DEPTH),
  localparam int LEN_W = clogb2(LOOK_AHEAD_BUFF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  core_data_valid,
  output logic [DATA_WIDTH-1:0] core_data,
  output logic                  core_clr,
  input  logic                  core_out_en,
  input  logic [POS_W-1:0]      core_match_pos,
  input  logic [LEN_W-1:0]      core_match_len,
  input  logic [DATA_WIDTH-1:0] core_next_sym,
  output logic                  tok_valid,
  input  logic                  tok_ready,
  output logic [POS_W-1:0]      tok_pos,
  output logic [LEN_W-1:0]      tok_len,
  output logic [DATA_WIDTH-1:0] tok_sym,
  output logic                  tok_sym_vld,
  output logic                  tok_last,
  output logic                  len_ovf,
  output logic [STAT_W-1:0]     byte_cnt,
  output logic [STAT_W-1:0]     tok_cnt
);

  localparam int TW = POS_W + LEN_W + DATA_WIDTH + 2;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(LOOK_AHEAD_BUFF_DEPTH - 1);

  state_e              state_q, state_d;
  logic                tok_free, run, beat;
  logic                load, clr;
  logic [TW-1:0]       tok_din, tok_q;
  logic [STAT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [STAT_W-1:0]   tok_cnt_q, tok_cnt_d;
  logic                len_ovf_q, len_ovf_d;

  assign tok_free = ~tok_valid | tok_ready;
  assign run      = (state_q == RUN);
  assign in_ready = run & tok_free;
  assign beat     = in_valid & in_ready;

  assign core_data_valid = beat;
  assign core_data       = in_data;
  assign core_clr        = clr;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clr     = 1'b0;
    tok_din = {core_match_pos, core_match_len, core_next_sym,
               1'b1, in_last};
    unique case (state_q)
      RUN: begin
        if (beat) begin
          load = core_out_en;
          if (in_last) state_d = core_out_en ? CLEAR : FLUSH;
        end
      end
      FLUSH: begin
        // Block ended mid-match: emit the pending match with no symbol.
        if (tok_free) begin
          load    = 1'b1;
          tok_din = {core_match_pos, core_match_len,
                     {DATA_WIDTH{1'b0}}, 1'b0, 1'b1};
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (tok_free) begin
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    tok_cnt_d  = tok_cnt_q;
    len_ovf_d  = len_ovf_q;
    if (clr) begin
      byte_cnt_d = '0;
      tok_cnt_d  = '0;
      len_ovf_d  = 1'b0;
    end else begin
      if (beat && byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 1'b1;
      if (load && tok_cnt_q != '1)  tok_cnt_d  = tok_cnt_q + 1'b1;
      if (beat && !core_out_en && core_match_len == LEN_MAX)
        len_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      byte_cnt_q <= '0;
      tok_cnt_q  <= '0;
      len_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tok_cnt_q  <= tok_cnt_d;
      len_ovf_q  <= len_ovf_d;
    end
  end

  lz77_tok_reg #(
    .W(TW)
  ) u_tok_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .din_i  (tok_din),
    .ready_i(tok_ready),
    .valid_o(tok_valid),
    .dout_o (tok_q)
  );

  assign {tok_pos, tok_len, tok_sym, tok_sym_vld, tok_last} = tok_q;

  assign byte_cnt = byte_cnt_q;
  assign tok_cnt  = tok_cnt_q;
  assign len_ovf  = len_ovf_q;

endmodule

// File: tb/tb_lz77_stream_ctrl.sv
// Bench for lz77_stream_ctrl: table of beats with expected tokens,
// scoreboard queue, and hand sequences for stalls, flush and reset.
module tb_lz77_stream_ctrl;
  import gzip_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       oen;
    logic [3:0] pos;
    logic [2:0] len;
    logic [7:0] sym;
    logic       etok;
    lz77_tok_t  exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       core_data_valid, core_clr, core_out_en;
  logic [7:0] core_data, core_next_sym;
  logic [3:0] core_match_pos;
  logic [2:0] core_match_len;
  logic       tok_valid, tok_ready, tok_sym_vld, tok_last, len_ovf;
  logic [3:0] tok_pos;
  logic [2:0] tok_len;
  logic [7:0] tok_sym;
  logic [15:0] byte_cnt, tok_cnt;

  int        n_vec = 0;
  int        n_bad = 0;
  int        clr_cnt = 0;
  lz77_tok_t q[$];
  lz77_tok_t got, expt;
  vec_t      tbl[27];

  lz77_stream_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .core_data_valid(core_data_valid),
    .core_data      (core_data),
    .core_clr       (core_clr),
    .core_out_en    (core_out_en),
    .core_match_pos (core_match_pos),
    .core_match_len (core_match_len),
    .core_next_sym  (core_next_sym),
    .tok_valid      (tok_valid),
    .tok_ready      (tok_ready),
    .tok_pos        (tok_pos),
    .tok_len        (tok_len),
    .tok_sym        (tok_sym),
    .tok_sym_vld    (tok_sym_vld),
    .tok_last       (tok_last),
    .len_ovf        (len_ovf),
    .byte_cnt       (byte_cnt),
    .tok_cnt        (tok_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [7:0] d, input logic last, input logic oen,
    input logic [3:0] pos, input logic [2:0] len, input logic [7:0] sym,
    input logic etok, input logic [3:0] ep, input logic [2:0] el,
    input logic [7:0] es, input logic ev, input logic elst);
    vec_t v;
    v.d = d; v.last = last; v.oen = oen;
    v.pos = pos; v.len = len; v.sym = sym;
    v.etok = etok;
    v.exp = '{pos: ep, len: el, sym: es, sym_vld: ev, last: elst};
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (core_clr) clr_cnt++;
      chk("core_dv", 32'(core_data_valid), 32'(in_valid & in_ready));
      if (core_data_valid) chk("core_data", 32'(core_data), 32'(in_data));
      if (tok_valid && tok_ready) begin
        got = '{pos: tok_pos, len: tok_len, sym: tok_sym,
                sym_vld: tok_sym_vld, last: tok_last};
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL token: got %0h expected none", got);
        end else begin
          expt = q.pop_front();
          chk("token", 32'(got), 32'(expt));
        end
      end
    end
  end

  task automatic beat(input int i);
    vec_t r;
    bit   ok;
    int   n;
    r  = tbl[i];
    ok = 1'b0;
    n  = 0;
    in_data        = r.d;
    in_last        = r.last;
    core_out_en    = r.oen;
    core_match_pos = r.pos;
    core_match_len = r.len;
    core_next_sym  = r.sym;
    in_valid       = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      if (ok && r.etok) q.push_back(r.exp);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL beat %0d: got no accept expected accept", i);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) beat(i);
  endtask

  task automatic wait_idle();
    bit idle;
    int n;
    idle = 1'b0;
    n    = 0;
    while (!idle && n < 50) begin
      @(negedge clk);
      idle = in_ready && !tok_valid && q.size() == 0;
      n++;
    end
    @(posedge clk);
    #1;
    if (!idle) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle: got busy expected idle, q=%0d", q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    core_out_en = 1'b0; core_match_pos = 4'd0;
    core_match_len = 3'd0; core_next_sym = 8'h00;
    tok_ready = 1'b1;

    tbl[0]  = mk("A",1'b0,1'b1,4'd0,3'd0,"A",1'b1,4'd0,3'd0,"A",1'b1,1'b0);
    tbl[1]  = mk("B",1'b0,1'b1,4'd0,3'd0,"B",1'b1,4'd0,3'd0,"B",1'b1,1'b0);
    tbl[2]  = mk("C",1'b0,1'b1,4'd0,3'd0,"C",1'b1,4'd0,3'd0,"C",1'b1,1'b0);
    tbl[3]  = mk("D",1'b1,1'b1,4'd0,3'd0,"D",1'b1,4'd0,3'd0,"D",1'b1,1'b1);
    tbl[4]  = mk("A",1'b0,1'b1,4'd0,3'd0,"A",1'b1,4'd0,3'd0,"A",1'b1,1'b0);
    tbl[5]  = mk("B",1'b0,1'b1,4'd0,3'd0,"B",1'b1,4'd0,3'd0,"B",1'b1,1'b0);
    tbl[6]  = mk("A",1'b0,1'b0,4'd1,3'd1,"A",1'b0,4'd0,3'd0,8'h0,1'b0,1'b0);
    tbl[7]  = mk("B",1'b0,1'b0,4'd1,3'd2,"B",1'b0,4'd0,3'd0,8'h0,1'b0,1'b0);
    tbl[8]  = mk("X",1'b1,1'b1,4'd1,3'd2,"X",1'b1,4'd1,3'd2,"X",1'b1,1'b1);
    tbl[9]  = mk("A",1'b0,1'b1,4'd0,3'd0,"A",1'b1,4'd0,3'd0,"A",1'b1,1'b0);
    tbl[10] = mk("B",1'b0,1'b1,4'd0,3'd0,"B",1'b1,4'd0,3'd0,"B",1'b1,1'b0);
    tbl[11] = mk("A",1'b0,1'b0,4'd2,3'd1,"A",1'b0,4'd0,3'd0,8'h0,1'b0,1'b0);
    tbl[12] = mk("B",1'b1,1'b0,4'd2,3'd2,"B",1'b1,4'd2,3'd2,8'h0,1'b0,1'b1);
    tbl[13] = mk("P",1'b0,1'b1,4'd0,3'd0,"P",1'b1,4'd0,3'd0,"P",1'b1,1'b0);
    tbl[14] = mk("Q",1'b0,1'b1,4'd5,3'd0,"Q",1'b1,4'd5,3'd0,"Q",1'b1,1'b0);
    tbl[15] = mk("R",1'b1,1'b1,4'd6,3'd3,"R",1'b1,4'd6,3'd3,"R",1'b1,1'b1);
    tbl[16] = mk("Z",1'b0,1'b1,4'd0,3'd0,"Z",1'b1,4'd0,3'd0,"Z",1'b1,1'b0);
    for (int k = 1; k <= 7; k++)
      tbl[16+k] = mk("Z",1'b0,1'b0,4'd0,3'(k),"Z",
                     1'b0,4'd0,3'd0,8'h0,1'b0,1'b0);
    tbl[24] = mk("Z",1'b1,1'b1,4'd0,3'd7,"Z",1'b1,4'd0,3'd7,"Z",1'b1,1'b1);
    tbl[25] = mk("N",1'b1,1'b0,4'd3,3'd1,"N",1'b0,4'd0,3'd0,8'h0,1'b0,1'b0);
    tbl[26] = mk("S",1'b1,1'b1,4'd0,3'd0,"S",1'b1,4'd0,3'd0,"S",1'b1,1'b1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst tok_valid", 32'(tok_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst core_clr", 32'(core_clr), 32'd0);
    chk("rst byte_cnt", 32'(byte_cnt), 32'd0);
    chk("rst tok_cnt", 32'(tok_cnt), 32'd0);
    chk("rst len_ovf", 32'(len_ovf), 32'd0);
    chk("rst tok_last", 32'(tok_last), 32'd0);

    run(0, 3);
    chk("abcd tok_cnt", 32'(tok_cnt), 32'd4);
    chk("abcd byte_cnt", 32'(byte_cnt), 32'd4);
    chk("abcd core_clr", 32'(core_clr), 32'd1);
    chk("abcd in_ready", 32'(in_ready), 32'd0);
    wait_idle();
    chk("abcd clr pulses", 32'(clr_cnt), 32'd1);
    chk("abcd cnt cleared", 32'(tok_cnt), 32'd0);

    run(4, 8);
    wait_idle();
    chk("abab-x clr pulses", 32'(clr_cnt), 32'd2);

    run(9, 12);
    chk("flush tok_valid", 32'(tok_valid), 32'd0);
    in_valid = 1'b1;
    #1;
    chk("flush in_ready", 32'(in_ready), 32'd0);
    chk("flush core_dv", 32'(core_data_valid), 32'd0);
    in_valid = 1'b0;
    wait_idle();
    chk("flush clr pulses", 32'(clr_cnt), 32'd3);

    tok_ready = 1'b0;
    beat(13);
    in_data = "Q"; in_last = 1'b0; core_out_en = 1'b1;
    core_next_sym = "Q"; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall core_dv", 32'(core_data_valid), 32'd0);
      chk("stall tok_sym", 32'(tok_sym), 32'("P"));
      chk("stall tok_valid", 32'(tok_valid), 32'd1);
      chk("stall byte_cnt", 32'(byte_cnt), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tok_ready = 1'b1;
    run(14, 15);
    chk("stall byte_cnt end", 32'(byte_cnt), 32'd3);
    chk("stall tok_cnt end", 32'(tok_cnt), 32'd3);
    wait_idle();
    chk("stall clr pulses", 32'(clr_cnt), 32'd4);

    run(16, 22);
    chk("ovf at len 6", 32'(len_ovf), 32'd0);
    beat(23);
    chk("ovf at len 7", 32'(len_ovf), 32'd1);
    beat(24);
    chk("ovf held", 32'(len_ovf), 32'd1);
    chk("ovf byte_cnt", 32'(byte_cnt), 32'd9);
    wait_idle();
    chk("ovf cleared", 32'(len_ovf), 32'd0);
    chk("ovf byte_cnt clr", 32'(byte_cnt), 32'd0);
    chk("ovf clr pulses", 32'(clr_cnt), 32'd5);

    tok_ready = 1'b0;
    beat(25);
    chk("pre-rst byte_cnt", 32'(byte_cnt), 32'd1);
    chk("pre-rst in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid rst tok_valid", 32'(tok_valid), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    chk("mid rst byte_cnt", 32'(byte_cnt), 32'd0);
    chk("mid rst tok_cnt", 32'(tok_cnt), 32'd0);
    chk("mid rst len_ovf", 32'(len_ovf), 32'd0);
    chk("mid rst core_clr", 32'(core_clr), 32'd0);

    tok_ready = 1'b1;
    beat(26);
    wait_idle();
    chk("single clr pulses", 32'(clr_cnt), 32'd6);
    chk("queue drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
